// File: rtl/util_irq_pkg.sv
// Shared constants and helpers for the IRQ-to-AXI-Stream block.
// Holds tdata width, maximum line count and drop-counter width.
package util_irq_pkg;

   localparam int TDATA_W = 8;
   localparam int MAX_IRQ = 32;
   localparam int DROP_W  = 16;
   localparam int IDX_W   = 5;
   localparam int CNT_W   = 6;

   // Number of set bits in a line vector.
   function automatic logic [CNT_W-1:0] popcnt(
      input logic [MAX_IRQ-1:0] v
   );
      logic [CNT_W-1:0] cnt;
      logic [MAX_IRQ-1:0] sh;
      cnt = '0;
      sh  = v;
      for (int i = 0; i < MAX_IRQ; i++) begin
         cnt = cnt + {{(CNT_W-1){1'b0}}, sh[0]};
         sh  = sh >> 1;
      end
      return cnt;
   endfunction

endpackage

// File: rtl/util_irq_rr_arbiter.sv
// Round-robin pick of one requesting line plus the last-grant pointer.
// Ports: clk, rst_n, req (request vector), load (commit grant), gnt_valid, gnt_idx.
module util_irq_rr_arbiter
   import util_irq_pkg::*;
#(
   parameter int N = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   input  logic             load,
   output logic             gnt_valid,
   output logic [IDX_W-1:0] gnt_idx
);

   logic [IDX_W-1:0] ptr;

   // Scan offsets from the far end so the nearest index above the
   // pointer is the last one written, i.e. the winner.
   function automatic logic [IDX_W:0] pick(
      input logic [N-1:0]     r,
      input logic [IDX_W-1:0] p
   );
      logic [IDX_W:0] res;
      logic [N-1:0]   sh;
      int             idx;
      res = '0;
      for (int k = N; k >= 1; k--) begin
         idx = int'(p) + k;
         if (idx >= N) idx = idx - N;
         sh = r >> idx;
         if (sh[0]) res = {1'b1, IDX_W'(idx)};
      end
      return res;
   endfunction

   assign {gnt_valid, gnt_idx} = pick(req, ptr);

   // Starting at the top index makes line 0 the first winner.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= IDX_W'(N - 1);
      end else if (load) begin
         ptr <= gnt_idx;
      end
   end

endmodule

// File: rtl/util_irq_rr2axis.sv
// Edge-detects IRQ lines and emits their numbers on an AXI-Stream port.
// Ports: clk, rst_n, irq, irq_mask, m_axis_t{data,valid,ready}, dropped_count, dropped_clr.
module util_irq_rr2axis
   import util_irq_pkg::*;
#(
   parameter int C_NUM_IRQ  = 8,
   parameter int C_IRQ_BASE = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [C_NUM_IRQ-1:0] irq,
   input  logic [C_NUM_IRQ-1:0] irq_mask,
   output logic [TDATA_W-1:0]   m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic [DROP_W-1:0]    dropped_count,
   input  logic                 dropped_clr
);

   logic [C_NUM_IRQ-1:0] irq_last;
   logic [C_NUM_IRQ-1:0] pending;
   logic [C_NUM_IRQ-1:0] rise;
   logic [C_NUM_IRQ-1:0] eligible;
   logic [C_NUM_IRQ-1:0] grant_oh;
   logic [C_NUM_IRQ-1:0] drop_vec;
   logic [C_NUM_IRQ-1:0] pending_nxt;
   logic                 gnt_valid;
   logic [IDX_W-1:0]     gnt_idx;
   logic                 load;
   logic [CNT_W-1:0]     drop_inc;
   logic [DROP_W:0]      drop_sum;

   assign rise     = irq & ~irq_last & ~irq_mask;
   assign eligible = pending & ~irq_mask;
   assign load     = gnt_valid & (~m_axis_tvalid | m_axis_tready);

   util_irq_rr_arbiter #(
      .N (C_NUM_IRQ)
   ) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (eligible),
      .load      (load),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   // A new edge on the line being loaded re-arms it rather than
   // counting as a drop.
   always_comb begin
      grant_oh = '0;
      if (load) grant_oh = C_NUM_IRQ'(1) << gnt_idx;
      drop_vec    = rise & pending & ~grant_oh;
      pending_nxt = (pending & ~grant_oh) | rise;
      drop_inc    = popcnt(MAX_IRQ'(drop_vec));
      drop_sum    = {1'b0, dropped_count} + (DROP_W+1)'(drop_inc);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_last <= '0;
         pending  <= '0;
      end else begin
         irq_last <= irq;
         pending  <= pending_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
      end else if (load) begin
         m_axis_tvalid <= 1'b1;
         m_axis_tdata  <= TDATA_W'(C_IRQ_BASE) + TDATA_W'(gnt_idx);
      end else if (m_axis_tready) begin
         m_axis_tvalid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dropped_count <= '0;
      end else if (dropped_clr) begin
         dropped_count <= '0;
      end else if (drop_sum[DROP_W]) begin
         dropped_count <= '1;
      end else begin
         dropped_count <= drop_sum[DROP_W-1:0];
      end
   end

endmodule
